// File: rtl/lwb_pkg.sv
// Shared constants and helpers for line_window_buffer.
// Width constants describe the default configuration (8-bit pixels, 11-pixel lines, 3-line window).
package lwb_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_LINE_LEN  = 11;
  localparam int DEF_NUM_LINES = 3;

  localparam int COL_W  = $clog2(DEF_LINE_LEN);
  localparam int SLOT_W = $clog2(DEF_NUM_LINES + 1);
  localparam int CNT_W  = $clog2(DEF_NUM_LINES + 2);

  // Advance a slot index around a ring of num_slots entries.
  function automatic int unsigned slot_inc(input int unsigned slot, input int unsigned num_slots);
    return (slot + 1 >= num_slots) ? 0 : slot + 1;
  endfunction

endpackage

// File: rtl/lwb_line_ram.sv
// One line slot: LINE_LEN x DATA_W store with a synchronous write port and an asynchronous read port.
// Contents are deliberately not reset.
module lwb_line_ram
  import lwb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LINE_LEN = DEF_LINE_LEN
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [$clog2(LINE_LEN)-1:0] waddr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic [$clog2(LINE_LEN)-1:0] raddr_i,
  output logic [DATA_W-1:0]           rdata_o
);

  logic [DATA_W-1:0] mem_q [LINE_LEN];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_window_buffer.sv
// Circular store of NUM_LINES+1 line slots emitting one NUM_LINES-tall column per handshake.
// Optional feature macro LWB_DROP_CNT_EN adds a saturating drop_cnt of refused writes.
module line_window_buffer
  import lwb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LINE_LEN  = DEF_LINE_LEN,
  parameter int NUM_LINES = DEF_NUM_LINES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           wr_valid,
  input  logic [DATA_W-1:0]              wr_data,
  output logic                           wr_ready,
  output logic                           rd_valid,
  output logic [NUM_LINES*DATA_W-1:0]    rd_data,
  input  logic                           rd_ready,
  output logic [$clog2(NUM_LINES+2)-1:0] lines_avail,
  output logic [$clog2(LINE_LEN)-1:0]    next_wr_col,
`ifdef LWB_DROP_CNT_EN
  output logic [15:0]                    drop_cnt,
`endif
  output logic [$clog2(LINE_LEN)-1:0]    next_rd_col
);

  localparam int NUM_SLOTS = NUM_LINES + 1;
  localparam int COL_BITS  = $clog2(LINE_LEN);
  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  localparam int CNT_BITS  = $clog2(NUM_LINES + 2);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(LINE_LEN - 1);

  logic [COL_BITS-1:0]  wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [SLOT_BITS-1:0] wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [CNT_BITS-1:0]  lines_q, lines_d;
  logic                 wr_fire, rd_fire, line_done, line_rel;
  logic [DATA_W-1:0]    slot_rdata [NUM_SLOTS];

  assign wr_ready  = (lines_q != CNT_BITS'(NUM_SLOTS));
  assign rd_valid  = (lines_q >= CNT_BITS'(NUM_LINES));
  assign wr_fire   = wr_valid & wr_ready;
  assign rd_fire   = rd_valid & rd_ready;
  assign line_done = wr_fire & (wr_col_q == LAST_COL);
  assign line_rel  = rd_fire & (rd_col_q == LAST_COL);

  always_comb begin
    wr_col_d  = wr_col_q;
    wr_slot_d = wr_slot_q;
    rd_col_d  = rd_col_q;
    rd_slot_d = rd_slot_q;
    lines_d   = lines_q;
    if (wr_fire) begin
      if (line_done) begin
        wr_col_d  = '0;
        wr_slot_d = SLOT_BITS'(slot_inc(32'(wr_slot_q), NUM_SLOTS));
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (line_rel) begin
        rd_col_d  = '0;
        rd_slot_d = SLOT_BITS'(slot_inc(32'(rd_slot_q), NUM_SLOTS));
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
    if (line_done && !line_rel) begin
      lines_d = lines_q + 1'b1;
    end else if (!line_done && line_rel) begin
      lines_d = lines_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_col_q  <= '0;
      wr_slot_q <= '0;
      rd_col_q  <= '0;
      rd_slot_q <= '0;
      lines_q   <= '0;
    end else if (flush) begin
      wr_col_q  <= '0;
      wr_slot_q <= '0;
      rd_col_q  <= '0;
      rd_slot_q <= '0;
      lines_q   <= '0;
    end else begin
      wr_col_q  <= wr_col_d;
      wr_slot_q <= wr_slot_d;
      rd_col_q  <= rd_col_d;
      rd_slot_q <= rd_slot_d;
      lines_q   <= lines_d;
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    lwb_line_ram #(
      .DATA_W  (DATA_W),
      .LINE_LEN(LINE_LEN)
    ) u_ram (
      .clk    (clk),
      .we_i   (wr_fire && (wr_slot_q == SLOT_BITS'(gi))),
      .waddr_i(wr_col_q),
      .wdata_i(wr_data),
      .raddr_i(rd_col_q),
      .rdata_o(slot_rdata[gi])
    );
  end

  // Slice k reads slot rd_slot+k; with NUM_LINES held the write slot is never in this range.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_col
    logic [SLOT_BITS:0]   sum;
    logic [SLOT_BITS-1:0] sel;
    assign sum = {1'b0, rd_slot_q} + (SLOT_BITS+1)'(gi);
    assign sel = (sum >= (SLOT_BITS+1)'(NUM_SLOTS)) ? SLOT_BITS'(sum - (SLOT_BITS+1)'(NUM_SLOTS))
                                                    : SLOT_BITS'(sum);
    assign rd_data[gi*DATA_W +: DATA_W] = rd_valid ? slot_rdata[sel] : '0;
  end

  assign lines_avail = lines_q;
  assign next_wr_col = wr_col_q;
  assign next_rd_col = rd_col_q;

`ifdef LWB_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (flush) begin
      drop_q <= '0;
    end else if (wr_valid && !wr_ready && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: queue-of-lines reference model checked every cycle plus directed literals.
// Drop counter checks are included when LWB_DROP_CNT_EN is defined.
module tb_line_window_buffer;
  import lwb_pkg::*;

  localparam int L  = DEF_LINE_LEN;
  localparam int N  = DEF_NUM_LINES;
  localparam int DW = DEF_DATA_W;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            flush    = 1'b0;
  logic            wr_valid = 1'b0;
  logic [DW-1:0]   wr_data  = '0;
  logic            rd_ready = 1'b0;
  logic            wr_ready, rd_valid;
  logic [N*DW-1:0] rd_data;
  logic [CNT_W-1:0] lines_avail;
  logic [COL_W-1:0] next_wr_col, next_rd_col;
`ifdef LWB_DROP_CNT_EN
  logic [15:0]     drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: complete lines as a flat pixel queue (oldest first), the partial line, read column.
  int held[$];
  int part[$];
  int rcol  = 0;
  int drops = 0;

  always #5 clk = ~clk;

  line_window_buffer #(
    .DATA_W   (DW),
    .LINE_LEN (L),
    .NUM_LINES(N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .lines_avail(lines_avail),
    .next_wr_col(next_wr_col),
`ifdef LWB_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .next_rd_col(next_rd_col)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] exp_col();
    logic [N*DW-1:0] v;
    v = '0;
    if (held.size() / L >= N) begin
      for (int k = 0; k < N; k++) begin
        v[k*DW +: DW] = DW'(held[k*L + rcol]);
      end
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int  av;
    bit  wf, rf;
    if (!rst_n || flush) begin
      held.delete();
      part.delete();
      rcol  = 0;
      drops = 0;
    end else begin
      av = held.size() / L;
      wf = wr_valid && (av != N + 1);
      rf = rd_ready && (av >= N);
      if (wr_valid && (av == N + 1) && drops < 65535) drops++;
      if (rf) begin
        $display("read col %0d data %h", rcol, exp_col());
        rcol++;
        if (rcol == L) begin
          rcol = 0;
          repeat (L) void'(held.pop_front());
        end
      end
      if (wf) begin
        part.push_back(int'(wr_data));
        if (part.size() == L) begin
          foreach (part[i]) held.push_back(part[i]);
          part.delete();
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int av;
    av = held.size() / L;
    chk("lines_avail", 64'(lines_avail), 64'(av));
    chk("wr_ready", 64'(wr_ready), 64'(av != N + 1));
    chk("rd_valid", 64'(rd_valid), 64'(av >= N));
    chk("rd_data", 64'(rd_data), 64'(exp_col()));
    chk("next_wr_col", 64'(next_wr_col), 64'(part.size()));
    chk("next_rd_col", 64'(next_rd_col), 64'(rcol));
`ifdef LWB_DROP_CNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(drops));
`endif
  end

  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_lines"}, 64'(lines_avail), 64'd0);
    chk({tag, "_wr_col"}, 64'(next_wr_col), 64'd0);
    chk({tag, "_rd_col"}, 64'(next_rd_col), 64'd0);
  endtask

  initial begin : stim
    int pix;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_values("por");
    rst_n = 1'b1;

    // Fill three lines with 1..33, no reads.
    for (int i = 1; i <= 33; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 32) chk("rd_valid_before_line3", 64'(rd_valid), 64'd0);
    end
    chk("first_col", 64'(rd_data), 64'h170C01);
    chk("fill_lines", 64'(lines_avail), 64'd3);
    chk("fill_rd_valid", 64'(rd_valid), 64'd1);

    // Fourth line fills the ring; one more pixel is refused.
    for (int i = 34; i <= 44; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 8'd45, 1'b0, 1'b0);
    chk("full_lines", 64'(lines_avail), 64'd4);
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    chk("full_wr_col", 64'(next_wr_col), 64'd0);
`ifdef LWB_DROP_CNT_EN
    chk("full_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // Drain one line of columns while full.
    for (int j = 0; j < 11; j++) begin
      chk("stream_col", 64'(rd_data), 64'({DW'(23 + j), DW'(12 + j), DW'(1 + j)}));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("release_lines", 64'(lines_avail), 64'd3);
    chk("release_wr_ready", 64'(wr_ready), 64'd1);
    chk("release_next_col", 64'(rd_data), 64'h22170C);

    // Three rounds of simultaneous line completion and release; slots wrap.
    pix = 46;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 11; j++) begin
        step(1'b1, DW'(pix), 1'b1, 1'b0);
        pix++;
      end
      chk("same_cycle_lines", 64'(lines_avail), 64'd3);
    end
    chk("wrap_col", 64'(rd_data), 64'h44392E);

    // Reset mid-line.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(pix), 1'b0, 1'b0);
      pix++;
    end
    chk("midline_wr_col", 64'(next_wr_col), 64'd5);
    wr_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_reset_values("async_rst");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 101; i <= 133; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    chk("rebuild_col", 64'(rd_data), 64'h7B7065);
    chk("rebuild_lines", 64'(lines_avail), 64'd3);

    // Held column under backpressure while writes continue.
    for (int i = 134; i <= 137; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      chk("hold_rd_data", 64'(rd_data), 64'h7B7065);
      chk("hold_rd_col", 64'(next_rd_col), 64'd0);
    end

    // Flush beats a same-cycle write and read.
    step(1'b1, 8'd200, 1'b1, 1'b1);
    chk_reset_values("flush");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 149) == 0));
    end
    step(1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
